// File: rtl/ama_riscv_imm_gen_pipe_pkg.sv
// Shared encodings for the registered immediate generator: select codes and
// the occupancy states of the two-entry output buffer.
package ama_riscv_imm_gen_pipe_pkg;

    localparam int IG_SEL_W = 3;

    typedef enum logic [IG_SEL_W-1:0] {
        IG_SEL_NONE = 3'd0,
        IG_SEL_I    = 3'd1,
        IG_SEL_S    = 3'd2,
        IG_SEL_B    = 3'd3,
        IG_SEL_J    = 3'd4,
        IG_SEL_U    = 3'd5,
        IG_SEL_Z    = 3'd6,
        IG_SEL_ILL  = 3'd7
    } ig_sel_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/ama_riscv_imm_gen_pipe_core.sv
// Combinational immediate extraction: instruction bits [31:7] plus a select
// code produce an XLEN-wide extended immediate and an illegal-select flag.
module ama_riscv_imm_gen_core
    import ama_riscv_imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IG_SEL_W-1:0] sel_i,
    input  logic [24:0]         inst_i,
    output logic [XLEN-1:0]     imm_o,
    output logic                err_o
);

    // Re-index so field slices read exactly like the ISA manual.
    logic [31:7] f;
    assign f = inst_i;

    always_comb begin
        imm_o = '0;
        err_o = 1'b0;
        case (ig_sel_t'(sel_i))
            IG_SEL_NONE: imm_o = '0;
            IG_SEL_I:    imm_o = XLEN'($signed(f[31:20]));
            IG_SEL_S:    imm_o = XLEN'($signed({f[31:25], f[11:7]}));
            IG_SEL_B:    imm_o = XLEN'($signed({f[31], f[7], f[30:25], f[11:8], 1'b0}));
            IG_SEL_J:    imm_o = XLEN'($signed({f[31], f[19:12], f[20], f[30:21], 1'b0}));
            IG_SEL_U:    imm_o = XLEN'($signed({f[31:12], 12'h000}));
            IG_SEL_Z:    imm_o = XLEN'(f[19:15]);
            default: begin
                imm_o = '0;
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ama_riscv_imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer between decode
// and execute; each immediate travels with a side-band tag.
module ama_riscv_imm_gen_pipe
    import ama_riscv_imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IG_SEL_W-1:0] in_sel,
    input  logic [24:0]         in_inst,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_imm,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    occ_state_t       state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [XLEN-1:0]  out_imm_q, skid_imm_q;
    logic [TAG_W-1:0] out_tag_q, skid_tag_q;
    logic             out_err_q, skid_err_q;

    logic [XLEN-1:0]  core_imm;
    logic             core_err;
    logic             accept, drain;
    logic             ld_out_core, ld_out_skid, ld_skid;

    ama_riscv_imm_gen_core #(
        .XLEN (XLEN)
    ) u_core (
        .sel_i  (in_sel),
        .inst_i (in_inst),
        .imm_o  (core_imm),
        .err_o  (core_err)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        ld_out_core = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        ld_out_core = 1'b1;
                        state_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({accept, drain})
                        2'b11: ld_out_core = 1'b1;
                        2'b10: begin
                            ld_skid = 1'b1;
                            state_d = OCC_TWO;
                        end
                        2'b01: state_d = OCC_EMPTY;
                        default: state_d = OCC_ONE;
                    endcase
                end
                OCC_TWO: begin
                    if (drain) begin
                        ld_out_skid = 1'b1;
                        if (accept) ld_skid = 1'b1;
                        else        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // Flush only clears state; payload registers keep their stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != OCC_TWO);
            out_valid_q <= (state_d != OCC_EMPTY);
            if (ld_out_core) begin
                out_imm_q <= core_imm;
                out_tag_q <= in_tag;
                out_err_q <= core_err;
            end else if (ld_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_tag_q <= skid_tag_q;
                out_err_q <= skid_err_q;
            end
            if (ld_skid) begin
                skid_imm_q <= core_imm;
                skid_tag_q <= in_tag;
                skid_err_q <= core_err;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ama_riscv_imm_gen_pipe.sv
// Bench for the registered immediate generator: XLEN=32 and XLEN=64 instances
// run in lockstep against a queue-based reference plus literal vectors.
module tb_ama_riscv_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  in_sel;
    logic [31:0] inst;
    logic [31:0] in_tag;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    always #5 clk = ~clk;

    ama_riscv_imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_sel(in_sel), .in_inst(inst[31:7]), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_err(err32)
    );

    ama_riscv_imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_sel(in_sel), .in_inst(inst[31:7]), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_err(err64)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] dut_out[$];

    // Reference immediate from field arithmetic on the whole 32-bit word.
    function automatic ent_t model_imm(input logic [2:0] sel, input logic [31:0] ins,
                                       input logic [31:0] tag);
        ent_t   e;
        longint s, hi, a, b, c, d;
        s = longint'($signed(ins));
        e.tag = tag;
        e.err = 1'b0;
        e.imm = 64'd0;
        case (sel)
            3'd1: e.imm = s >>> 20;
            3'd2: begin
                hi = s >>> 25;
                a  = longint'((ins >> 7) & 32'h1f);
                e.imm = (hi * 32) + a;
            end
            3'd3: begin
                hi = s >>> 31;
                a  = longint'((ins >> 7) & 32'h1);
                b  = longint'((ins >> 25) & 32'h3f);
                c  = longint'((ins >> 8) & 32'hf);
                e.imm = (hi * 4096) + a * 2048 + b * 32 + c * 2;
            end
            3'd4: begin
                hi = s >>> 31;
                a  = longint'((ins >> 12) & 32'hff);
                b  = longint'((ins >> 20) & 32'h1);
                c  = longint'((ins >> 21) & 32'h3ff);
                e.imm = (hi * 1048576) + a * 4096 + b * 2048 + c * 2;
            end
            3'd5: begin
                d = s >>> 12;
                e.imm = d * 4096;
            end
            3'd6: e.imm = 64'((ins >> 15) & 32'h1f);
            3'd7: e.err = 1'b1;
            default: e.imm = 64'd0;
        endcase
        return e;
    endfunction

    // Reference occupancy: FIFO of at most two entries.
    always @(posedge clk or posedge rst) begin
        ent_t e;
        bit   acc, drn;
        if (rst || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            e   = model_imm(in_sel, inst, in_tag);
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
    end

    // Every cycle: DUT outputs against the reference, on both widths.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
            chk("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
            chk("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
            chk("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk("imm32", 64'(imm32), 64'(mq[0].imm[31:0]));
                chk("imm64", imm64, mq[0].imm);
                chk("tag32", 64'(tag32), 64'(mq[0].tag));
                chk("tag64", 64'(tag64), 64'(mq[0].tag));
                chk("err32", 64'(err32), 64'(mq[0].err));
                chk("err64", 64'(err64), 64'(mq[0].err));
            end
            if (out_valid32 && out_ready) dut_out.push_back(tag32);
        end
    end

    task automatic push_check(input string name, input logic [2:0] sel, input logic [31:0] ins,
                              input logic [31:0] tag, input logic [31:0] e32,
                              input logic [63:0] e64, input logic eerr);
        @(posedge clk); #1;
        in_valid = 1'b1; in_sel = sel; inst = ins; in_tag = tag; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid32 & out_valid64), 64'd1);
        chk({name, "_imm32"}, 64'(imm32), 64'(e32));
        chk({name, "_imm64"}, imm64, e64);
        chk({name, "_err"}, 64'({err32, err64}), eerr ? 64'd3 : 64'd0);
        chk({name, "_tag"}, 64'(tag32), 64'(tag));
        $display("txn %s sel=%0d inst=%h tag=%0d imm32=%h imm64=%h err=%b",
                 name, sel, ins, tag, imm32, imm64, err32);
    endtask

    task automatic fill_two(input logic [31:0] t1, input logic [31:0] t2);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1; inst = 32'h00500093; in_tag = t1;
        @(posedge clk); #1;
        in_tag = t2; inst = 32'hFFB00093;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sel = 3'd0; inst = 32'd0; in_tag = 32'd0;
        #7;
        chk("rst_out_valid", 64'({out_valid32, out_valid64}), 64'd0);
        chk("rst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
        chk("rst_imm", imm64 | 64'(imm32), 64'd0);
        chk("rst_tag", 64'(tag32 | tag64), 64'd0);
        chk("rst_err", 64'({err32, err64}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        push_check("I_neg1", 3'd1, 32'hFFF00093, 32'd10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        push_check("B",      3'd3, 32'hFE000EE3, 32'd11, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        push_check("J",      3'd4, 32'h800000EF, 32'd12, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
        push_check("U_pos",  3'd5, 32'h123450B7, 32'd13, 32'h12345000, 64'h0000000012345000, 1'b0);
        push_check("Z",      3'd6, 32'h000FD073, 32'd14, 32'h0000001F, 64'h000000000000001F, 1'b0);
        push_check("ILL",    3'd7, 32'hFFFFFFFF, 32'd15, 32'h00000000, 64'h0, 1'b1);
        push_check("U_neg",  3'd5, 32'h800000B7, 32'd16, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        push_check("I_max",  3'd1, 32'h7FF00093, 32'd17, 32'h000007FF, 64'h00000000000007FF, 1'b0);
        push_check("S_pos",  3'd2, 32'h00A12423, 32'd18, 32'h00000008, 64'h0000000000000008, 1'b0);
        push_check("NONE",   3'd0, 32'hFFFFFFFF, 32'd19, 32'h00000000, 64'h0, 1'b0);

        // Backpressure: tags 1,2,3 with the consumer stalled.
        @(posedge clk); #1;
        dut_out.delete();
        fill_two(32'd1, 32'd2);
        in_tag = 32'd3; inst = 32'h00300093;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready32), 64'd0);
            chk("bp_hold_tag", 64'(tag32), 64'd1);
            chk("bp_hold_imm", 64'(imm32), 64'd5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = in_ready32;
            @(posedge clk); #1;
        end
        chk("bp_tag3_accepted", 64'(got), 64'd1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 64'(dut_out.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < dut_out.size()) chk("bp_order", 64'(dut_out[i]), 64'(i + 1));
        end
        $display("txn backpressure drained=%0d", dut_out.size());

        // Flush while full, with a same-cycle input offered.
        fill_two(32'h11, 32'h12);
        flush = 1'b1; in_valid = 1'b1; in_tag = 32'h55;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid32), 64'd0);
        chk("flush_in_ready", 64'(in_ready32), 64'd1);
        dut_out.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_leak", 64'(dut_out.size()), 64'd0);
        $display("txn flush leaked=%0d", dut_out.size());
        push_check("post_flush", 3'd1, 32'h00100093, 32'd20, 32'd1, 64'd1, 1'b0);

        // Asynchronous reset while full and still offering input.
        fill_two(32'd7, 32'd8);
        in_tag = 32'h99;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'({out_valid32, out_valid64}), 64'd0);
        chk("arst_in_ready", 64'({in_ready32, in_ready64}), 64'd3);
        $display("txn async_reset out_valid=%b in_ready=%b", out_valid32, in_ready32);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        push_check("post_rst", 3'd1, 32'hFFF00093, 32'd9, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
